// File: rtl/rr_bus_arbiter_pkg.sv
// Shared definitions for the gpiomem bus arbiter: default widths, rw encoding
// and the arbiter state type.
package bus_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width that stays legal (>=1) even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_picker.sv
// Rotating-priority selector: finds the first asserted request at or above
// rr_ptr, wrapping back to index 0.
module rr_picker #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] onehot,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_CORES) begin
                j = j - NUM_CORES;
            end
            if (!valid && req[j]) begin
                valid     = 1'b1;
                idx       = IDX_W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing the single gpiomem port between NUM_CORES cores,
// with a bounded hold time when another core is waiting.
module rr_bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_HOLD  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             req,
    output logic [NUM_CORES-1:0]             grant,
    input  logic [NUM_CORES*ADDR_W-1:0]      core_addr,
    input  logic [NUM_CORES-1:0]             core_rw,
    input  logic [NUM_CORES*DATA_W-1:0]      core_wdata,
    output logic [DATA_W-1:0]                core_rdata,
    output logic [ADDR_W-1:0]                mem_address,
    output logic [DATA_W-1:0]                mem_data_in,
    input  logic [DATA_W-1:0]                mem_data_out,
    output logic                             mem_rw,
    output logic                             busy,
    output logic [idx_width(NUM_CORES)-1:0]  owner_id,
    output logic                             timeout
);

    localparam int IDX_W    = idx_width(NUM_CORES);
    localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_t           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [HOLD_W-1:0]    hold_cnt;

    logic [NUM_CORES-1:0] pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 owner_req;
    logic                 others_waiting;
    logic                 hold_expired;
    logic                 force_release;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        if (v >= HOLD_W'(MAX_HOLD)) begin
            return HOLD_W'(MAX_HOLD);
        end
        return v + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
        if (int'(cur) >= NUM_CORES - 1) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign owner_req      = req[owner_id];
    assign others_waiting = |(req & ~grant);
    // ">=" rather than "==" so a counter that saturated during an uncontended
    // hold still releases as soon as someone else starts waiting.
    assign hold_expired   = (MAX_HOLD != 0) && (hold_cnt >= HOLD_W'(HOLD_LIM));
    assign force_release  = owner_req && hold_expired && others_waiting;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= GRANT;
                        grant    <= pick_onehot;
                        owner_id <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || force_release) begin
                        state    <= IDLE;
                        grant    <= '0;
                        rr_ptr   <= next_ptr(owner_id);
                        hold_cnt <= '0;
                        timeout  <= force_release;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Memory port follows the registered owner; idle bus drives zeros as a read.
    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_rw      = RW_READ;
        if (state == GRANT) begin
            mem_address = core_addr[int'(owner_id)*ADDR_W +: ADDR_W];
            mem_data_in = core_wdata[int'(owner_id)*DATA_W +: DATA_W];
            mem_rw      = core_rw[owner_id];
        end
    end

    assign busy       = |grant;
    assign core_rdata = mem_data_out;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter: reset, tie-break/alternation, a per-cycle
// vector table with timeouts, reset during a write grant and a long solo hold.
module tb_rr_bus_arbiter;

    localparam logic [8:0] A0 = 9'h1F0;
    localparam logic [8:0] A1 = 9'h033;
    localparam logic [7:0] D0 = 8'hA5;
    localparam logic [7:0] D1 = 8'h3C;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [17:0] core_addr;
    logic [1:0]  core_rw;
    logic [15:0] core_wdata;
    logic [7:0]  core_rdata;
    logic [8:0]  mem_address;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_rw;
    logic        busy;
    logic [0:0]  owner_id;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] rw;
        logic [1:0] g;
        logic       to;
        logic       mrw;
    } vec_t;

    vec_t tbl [21];

    rr_bus_arbiter #(
        .NUM_CORES (2),
        .ADDR_W    (9),
        .DATA_W    (8),
        .MAX_HOLD  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .grant        (grant),
        .core_addr    (core_addr),
        .core_rw      (core_rw),
        .core_wdata   (core_wdata),
        .core_rdata   (core_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_rw       (mem_rw),
        .busy         (busy),
        .owner_id     (owner_id),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bus contents derived from the expected grant and the bench's own constants.
    task automatic chk_bus(input string tag, input logic [1:0] eg, input logic eto, input logic emrw);
        logic [8:0] ea;
        logic [7:0] ed;
        ea = 9'h0;
        ed = 8'h0;
        if (eg == 2'b01) begin
            ea = A0;
            ed = D0;
        end else if (eg == 2'b10) begin
            ea = A1;
            ed = D1;
        end
        chk({tag, ".grant"},   32'(grant),       32'(eg));
        chk({tag, ".busy"},    32'(busy),        32'(eg != 2'b00));
        chk({tag, ".timeout"}, 32'(timeout),     32'(eto));
        chk({tag, ".mem_rw"},  32'(mem_rw),      32'(emrw));
        chk({tag, ".addr"},    32'(mem_address), 32'(ea));
        chk({tag, ".din"},     32'(mem_data_in), 32'(ed));
    endtask

    initial begin
        core_addr    = {A1, A0};
        core_wdata   = {D1, D0};
        core_rw      = 2'b11;
        req          = 2'b11;
        reset        = 1'b1;
        mem_data_out = 8'h00;

        tbl[0]  = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
        tbl[1]  = '{2'b01, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{2'b11, 2'b11, 2'b10, 1'b0, 1'b1};
        tbl[4]  = '{2'b01, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{2'b01, 2'b11, 2'b01, 1'b0, 1'b1};
        tbl[6]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[7]  = '{2'b11, 2'b11, 2'b10, 1'b0, 1'b1};
        tbl[8]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b1};
        tbl[11] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[13] = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[14] = '{2'b11, 2'b10, 2'b10, 1'b0, 1'b1};
        tbl[15] = '{2'b11, 2'b10, 2'b10, 1'b0, 1'b1};
        tbl[16] = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b0};
        tbl[17] = '{2'b11, 2'b00, 2'b10, 1'b0, 1'b0};
        tbl[18] = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[19] = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
        tbl[20] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

        // Reset held 3 cycles with both cores requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bus("reset", 2'b00, 1'b0, 1'b0);
            chk("reset.owner", 32'(owner_id), 32'd0);
        end

        // Tie out of reset goes to core0, then strict alternation with dead cycles.
        reset = 1'b0;
        tick();
        chk_bus("tie.c0", 2'b01, 1'b0, 1'b1);
        chk("tie.owner0", 32'(owner_id), 32'd0);
        req = 2'b10;
        tick();
        chk_bus("tie.dead0", 2'b00, 1'b0, 1'b0);
        tick();
        chk_bus("tie.c1", 2'b10, 1'b0, 1'b1);
        chk("tie.owner1", 32'(owner_id), 32'd1);
        req = 2'b01;
        tick();
        chk_bus("tie.dead1", 2'b00, 1'b0, 1'b0);
        tick();
        chk_bus("tie.c0b", 2'b01, 1'b0, 1'b1);
        req = 2'b00;
        tick();
        chk_bus("tie.idle", 2'b00, 1'b0, 1'b0);

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Per-cycle vectors: single core, alternation and forced releases (MAX_HOLD=4).
        for (int i = 0; i < 21; i++) begin
            req          = tbl[i].req;
            core_rw      = tbl[i].rw;
            mem_data_out = 8'(8'h40 + i);
            tick();
            chk_bus($sformatf("vec%0d", i), tbl[i].g, tbl[i].to, tbl[i].mrw);
            chk($sformatf("vec%0d.rdata", i), 32'(core_rdata), 32'(8'h40 + i));
        end

        // Reset during a core1 write: grant and write strobe drop, pointer returns to 0.
        req     = 2'b10;
        core_rw = 2'b10;
        tick();
        chk_bus("rstw.grant1", 2'b10, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        chk_bus("rstw.reset", 2'b00, 1'b0, 1'b0);
        reset   = 1'b0;
        req     = 2'b11;
        core_rw = 2'b00;
        tick();
        chk_bus("rstw.ptr0", 2'b01, 1'b0, 1'b0);
        chk("rstw.owner", 32'(owner_id), 32'd0);

        // Solo hold well past MAX_HOLD: no release, no timeout.
        req = 2'b01;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("solo.grant", 32'(grant), 32'(2'b01));
            chk("solo.timeout", 32'(timeout), 32'd0);
        end
        req = 2'b00;
        tick();
        chk_bus("solo.release", 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
